// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive buffer, FWFT FIFO with async-valid sync.
// Ports: clk_i, reset_i, rx_valid_i, rx_data_i, rd_ready_i, rd_valid_o,
//   rd_data_o, count_o, full_o, overflow_o, clr_ovf_i.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              overflow_o,
  input  logic              clr_ovf_i
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = (ADDR_W)'(1);

  logic sync1;
  logic sync2;
  logic sync3;
  logic wr_evt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_n;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_n;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] head_n;
  logic              ovf_q;

  logic full;
  logic valid;
  logic pop;
  logic push;

  assign wr_evt = sync2 & ~sync3;

  assign full  = (count_q == FULL_CNT);
  assign valid = (count_q != '0);
  assign pop   = valid & rd_ready_i;
  assign push  = wr_evt & (~full | pop);

  always_comb begin
    rd_ptr_n = rd_ptr;
    if (pop) rd_ptr_n = rd_ptr + PTR_ONE;
  end

  always_comb begin
    count_n = count_q;
    unique case (1'b1)
      (push & ~pop): count_n = count_q + CNT_ONE;
      (pop & ~push): count_n = count_q - CNT_ONE;
      default:       count_n = count_q;
    endcase
  end

  // The byte being written lands at the new head only when the FIFO
  // holds exactly that byte afterwards; bypass it around the array.
  always_comb begin
    head_n = mem[rd_ptr_n];
    if (push && (wr_ptr == rd_ptr_n)) head_n = rx_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1   <= rx_valid_i;
      sync2   <= sync1;
      sync3   <= sync2;
      rd_ptr  <= rd_ptr_n;
      count_q <= count_n;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      // Head register keeps the last byte once the FIFO drains.
      if (count_n != '0) data_q <= head_n;
      // A fresh drop beats a clear in the same cycle.
      if (wr_evt & full & ~pop) ovf_q <= 1'b1;
      else if (clr_ovf_i)       ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end

  assign rd_valid_o = valid;
  assign rd_data_o  = data_q;
  assign count_o    = count_q;
  assign full_o     = full;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo.
// Table of push/pop/clear records plus hand sequences.
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       rd_ready_i;
  logic       rd_valid_o;
  logic [7:0] rd_data_o;
  logic [4:0] count_o;
  logic       full_o;
  logic       overflow_o;
  logic       clr_ovf_i;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .rd_ready_i (rd_ready_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .clr_ovf_i  (clr_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_CLR} op_t;

  typedef struct {
    op_t        op;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic [4:0] e_cnt;
    logic       e_full;
    logic       e_ovf;
    logic [7:0] e_head;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic rdy,
                      input logic clr);
    rx_data_i  = d;
    rx_valid_i = 1'b1;
    cyc();
    cyc();
    rd_ready_i = rdy;
    clr_ovf_i  = clr;
    cyc();
    rd_ready_i = 1'b0;
    clr_ovf_i  = 1'b0;
    rx_valid_i = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic pop();
    rd_ready_i = 1'b1;
    cyc();
    rd_ready_i = 1'b0;
  endtask

  task automatic add(input op_t op, input logic [7:0] d, input logic rdy,
                     input logic clr, input logic [4:0] c, input logic f,
                     input logic o, input logic [7:0] h);
    vec_t v;
    v.op = op; v.data = d; v.rdy = rdy; v.clr = clr;
    v.e_cnt = c; v.e_full = f; v.e_ovf = o; v.e_head = h;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] q[16];

    // Fill 0x10..0x1F, then a dropped 0x20.
    for (int i = 0; i < 16; i++)
      add(OP_PUSH, 8'(8'h10 + i), 1'b0, 1'b0, 5'(i + 1),
          (i == 15), 1'b0, 8'h10);
    add(OP_PUSH, 8'h20, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1, 8'h10);
    add(OP_CLR,  8'h00, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 8'h10);
    // Full with pop on the write edge: 0x10 leaves, 0x21 enters.
    add(OP_PUSH, 8'h21, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 8'h11);
    // Clear coincident with a drop: set wins.
    add(OP_PUSH, 8'h22, 1'b0, 1'b1, 5'd16, 1'b1, 1'b1, 8'h11);
    add(OP_CLR,  8'h00, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 8'h11);
    for (int i = 0; i < 15; i++) q[i] = 8'(8'h11 + i);
    q[15] = 8'h21;
    for (int k = 0; k < 16; k++)
      add(OP_POP, q[k], 1'b1, 1'b0, 5'(15 - k), 1'b0, 1'b0,
          (k < 15) ? q[k + 1] : 8'h21);

    reset_i    = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    rd_ready_i = 1'b0;
    clr_ovf_i  = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_data",  32'(rd_data_o),  32'd0);
    chk("rst_count", 32'(count_o),    32'd0);
    chk("rst_full",  32'(full_o),     32'd0);
    chk("rst_ovf",   32'(overflow_o), 32'd0);
    reset_i = 1'b0;
    cyc();
    cyc();

    // Single byte with a long valid level.
    rx_data_i  = 8'hA5;
    rx_valid_i = 1'b1;
    cyc();
    cyc();
    chk("lat_edge2_valid", 32'(rd_valid_o), 32'd0);
    cyc();
    chk("lat_edge3_valid", 32'(rd_valid_o), 32'd1);
    chk("lat_edge3_data",  32'(rd_data_o),  32'hA5);
    chk("lat_edge3_count", 32'(count_o),    32'd1);
    for (int i = 0; i < 47; i++) cyc();
    chk("long_lvl_count", 32'(count_o), 32'd1);
    rx_valid_i = 1'b0;
    cyc();
    cyc();
    pop();
    chk("pop1_count", 32'(count_o),    32'd0);
    chk("pop1_valid", 32'(rd_valid_o), 32'd0);
    chk("pop1_hold",  32'(rd_data_o),  32'hA5);
    rd_ready_i = 1'b1;
    cyc();
    cyc();
    rd_ready_i = 1'b0;
    chk("empty_rdy_count", 32'(count_o), 32'd0);

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      unique case (tbl[i].op)
        OP_PUSH: push(tbl[i].data, tbl[i].rdy, tbl[i].clr);
        OP_POP: begin
          chk({tag, "_pre_head"}, 32'(rd_data_o), 32'(tbl[i].data));
          pop();
        end
        default: begin
          clr_ovf_i = 1'b1;
          cyc();
          clr_ovf_i = 1'b0;
        end
      endcase
      chk({tag, "_count"}, 32'(count_o),    32'(tbl[i].e_cnt));
      chk({tag, "_full"},  32'(full_o),     32'(tbl[i].e_full));
      chk({tag, "_ovf"},   32'(overflow_o), 32'(tbl[i].e_ovf));
      chk({tag, "_valid"}, 32'(rd_valid_o), 32'(tbl[i].e_cnt != 0));
      chk({tag, "_head"},  32'(rd_data_o),  32'(tbl[i].e_head));
    end

    // Ordering across two pointer wraps, drained as it arrives.
    for (int i = 0; i < 40; i++) begin
      push(8'(i), 1'b0, 1'b0);
      chk($sformatf("ord%0d_valid", i), 32'(rd_valid_o), 32'd1);
      chk($sformatf("ord%0d_data", i),  32'(rd_data_o),  32'(i));
      pop();
    end
    chk("ord_count", 32'(count_o),    32'd0);
    chk("ord_ovf",   32'(overflow_o), 32'd0);

    // Reset mid-stream, checked before the next clock edge.
    push(8'h5A, 1'b0, 1'b0);
    push(8'h6B, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count_o), 32'd2);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(rd_valid_o), 32'd0);
    chk("async_rst_data",  32'(rd_data_o),  32'd0);
    chk("async_rst_count", 32'(count_o),    32'd0);
    cyc();
    reset_i = 1'b0;
    cyc();
    chk("post_rst_count", 32'(count_o), 32'd0);
    push(8'hC3, 1'b0, 1'b0);
    chk("post_rst_push_count", 32'(count_o),   32'd1);
    chk("post_rst_push_data",  32'(rd_data_o), 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
